// File: rtl/jb_dfe_nco_pkg.sv
// Shared definitions for the DFE NCO phase accumulator and its latency aligner:
// channel ordering of the TDM stream, default phase types and a width helper.
package jb_dfe_nco_pkg;

    // Default accumulator width used by the phase/FCW typedefs.
    localparam int NCO_PHASE_BW = 32;

    typedef logic [NCO_PHASE_BW-1:0] phase_t;
    typedef logic [NCO_PHASE_BW-1:0] fcw_t;

    // TDM slot order: carrier-major, antenna-minor.
    typedef enum logic [2:0] {
        CH_C0A0 = 3'd0,
        CH_C0A1 = 3'd1,
        CH_C0A2 = 3'd2,
        CH_C0A3 = 3'd3,
        CH_C1A0 = 3'd4,
        CH_C1A1 = 3'd5,
        CH_C1A2 = 3'd6,
        CH_C1A3 = 3'd7
    } tdm_ch_e;

    // Slot index that starts a TDM round; updates are applied there.
    localparam int CH_ROUND_START = 0;

    // Width of a channel index for n channels (at least 1 bit).
    function automatic int ch_bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jb_dfe_nco_delay_line.sv
// Valid + data register pipeline. Every stage resets to zero; a stage's data
// only loads when its incoming valid is high, so the tail holds the last
// valid word between samples.
module jb_dfe_nco_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign valid_out = valid_in;
            assign data_out  = data_in;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_q;
            logic [WIDTH-1:0] dat_q [DEPTH];

            // Shift valid every cycle; advance data only behind a valid word.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
                end else begin
                    vld_q[0] <= valid_in;
                    if (valid_in) dat_q[0] <= data_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign valid_out = vld_q[DEPTH-1];
            assign data_out  = dat_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/jb_dfe_nco_phase_acc.sv
// TDM NCO phase accumulator. One accumulator per interleaved channel; each
// valid slot emits the channel's pre-update phase and advances it by the
// active FCW. FCW commits and phase syncs are armed by pulses and applied
// together at the first round start after the pulse.
//
// Handshake: tvalid_in marks one sample slot per cycle with no backpressure;
// tvalid_out is asserted exactly NCO_LATENCY cycles later for that slot and
// tuser_out/phase_out are only meaningful while tvalid_out is high (they
// hold their last value otherwise).
module jb_dfe_nco_phase_acc
    import jb_dfe_nco_pkg::*;
#(
    parameter int N_CHANNELS  = 8,
    parameter int PHASE_BW    = 32,
    parameter int OUT_BW      = 16,
    parameter int NCO_LATENCY = 3,
    localparam int CH_BW      = ch_bw(N_CHANNELS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tvalid_in,
    input  logic                fcw_wr_en,
    input  logic [CH_BW-1:0]    fcw_wr_addr,
    input  logic [PHASE_BW-1:0] fcw_wr_data,
    input  logic                fcw_commit,
    input  logic                phase_sync,
    output logic                tvalid_out,
    output logic [CH_BW-1:0]    tuser_out,
    output logic [OUT_BW-1:0]   phase_out,
    output logic                update_pending
);

    logic [PHASE_BW-1:0] acc        [N_CHANNELS];
    logic [PHASE_BW-1:0] fcw_shadow [N_CHANNELS];
    logic [PHASE_BW-1:0] fcw_active [N_CHANNELS];
    logic [N_CHANNELS-1:0] zero_mask;
    logic [CH_BW-1:0]    ch;
    logic                commit_flag;
    logic                sync_flag;

    logic                boundary;
    logic                commit_apply;
    logic                sync_apply;
    logic                commit_flag_nxt;
    logic                sync_flag_nxt;
    logic                slot_zero;
    logic [PHASE_BW-1:0] fcw_sel;
    logic [PHASE_BW-1:0] phase_pre;
    logic [PHASE_BW-1:0] acc_nxt;

    logic                s0_valid;
    logic [CH_BW+OUT_BW-1:0] s0_data;
    logic [CH_BW+OUT_BW-1:0] out_data;

    // Slot decode: pick the word and starting phase for the current channel.
    always_comb begin
        boundary     = tvalid_in && (ch == CH_BW'(CH_ROUND_START));
        commit_apply = boundary && commit_flag;
        sync_apply   = boundary && sync_flag;
        fcw_sel      = commit_apply ? fcw_shadow[ch] : fcw_active[ch];
        slot_zero    = sync_apply || zero_mask[ch];
        phase_pre    = slot_zero ? '0 : acc[ch];
        acc_nxt      = phase_pre + fcw_sel;
    end

    // Sticky arm flags; a pulse coinciding with its own apply is absorbed.
    always_comb begin
        commit_flag_nxt = commit_flag;
        sync_flag_nxt   = sync_flag;
        if (commit_apply)    commit_flag_nxt = 1'b0;
        else if (fcw_commit) commit_flag_nxt = 1'b1;
        if (sync_apply)      sync_flag_nxt   = 1'b0;
        else if (phase_sync) sync_flag_nxt   = 1'b1;
    end

    // Channel counter, arm flags and the registered pending indicator.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ch             <= '0;
            commit_flag    <= 1'b0;
            sync_flag      <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            commit_flag    <= commit_flag_nxt;
            sync_flag      <= sync_flag_nxt;
            update_pending <= commit_flag_nxt | sync_flag_nxt;
            if (tvalid_in) begin
                if (ch == CH_BW'(N_CHANNELS - 1)) ch <= '0;
                else                              ch <= ch + 1'b1;
            end
        end
    end

    // Host shadow writes; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CHANNELS; i++) fcw_shadow[i] <= '0;
        end else if (fcw_wr_en && (int'(fcw_wr_addr) < N_CHANNELS)) begin
            fcw_shadow[fcw_wr_addr] <= fcw_wr_data;
        end
    end

    // Atomic copy of every shadow word at the applying round start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CHANNELS; i++) fcw_active[i] <= '0;
        end else if (commit_apply) begin
            for (int i = 0; i < N_CHANNELS; i++) fcw_active[i] <= fcw_shadow[i];
        end
    end

    // Per-channel accumulator update on its own slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CHANNELS; i++) acc[i] <= '0;
        end else if (tvalid_in) begin
            acc[ch] <= acc_nxt;
        end
    end

    // Zero mask: a sync marks every channel, channel 0 is consumed at once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            zero_mask <= '0;
        end else if (tvalid_in) begin
            if (sync_apply) zero_mask <= {{(N_CHANNELS-1){1'b1}}, 1'b0};
            else            zero_mask[ch] <= 1'b0;
        end
    end

    // First output stage: capture channel and truncated pre-update phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= tvalid_in;
            if (tvalid_in) s0_data <= {ch, phase_pre[PHASE_BW-1 -: OUT_BW]};
        end
    end

    jb_dfe_nco_delay_line #(
        .DEPTH (NCO_LATENCY - 1),
        .WIDTH (CH_BW + OUT_BW)
    ) u_delay (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (s0_valid),
        .data_in   (s0_data),
        .valid_out (tvalid_out),
        .data_out  (out_data)
    );

    assign tuser_out = out_data[CH_BW+OUT_BW-1 -: CH_BW];
    assign phase_out = out_data[OUT_BW-1:0];

endmodule

// File: tb/tb_jb_dfe_nco_phase_acc.sv
// Bench for jb_dfe_nco_phase_acc: directed scenarios plus random traffic,
// scored against a per-channel arithmetic model of the NCO.
module tb_jb_dfe_nco_phase_acc;

    localparam int N   = 8;
    localparam int PB  = 32;
    localparam int OB  = 16;
    localparam int LAT = 3;
    localparam int CW  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn = 1'b0;
    logic          tvalid_in = 1'b0;
    logic          fcw_wr_en = 1'b0;
    logic [CW-1:0] fcw_wr_addr = '0;
    logic [PB-1:0] fcw_wr_data = '0;
    logic          fcw_commit = 1'b0;
    logic          phase_sync = 1'b0;
    logic          tvalid_out;
    logic [CW-1:0] tuser_out;
    logic [OB-1:0] phase_out;
    logic          update_pending;

    jb_dfe_nco_phase_acc #(
        .N_CHANNELS (N), .PHASE_BW (PB), .OUT_BW (OB), .NCO_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .tvalid_in      (tvalid_in),
        .fcw_wr_en      (fcw_wr_en),
        .fcw_wr_addr    (fcw_wr_addr),
        .fcw_wr_data    (fcw_wr_data),
        .fcw_commit     (fcw_commit),
        .phase_sync     (phase_sync),
        .tvalid_out     (tvalid_out),
        .tuser_out      (tuser_out),
        .phase_out      (phase_out),
        .update_pending (update_pending)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        logic [CW-1:0] tuser;
        logic [OB-1:0] phase;
    } exp_t;

    exp_t exp_q[$];

    logic [PB-1:0] m_phase  [N];
    logic [PB-1:0] m_shadow [N];
    logic [PB-1:0] m_active [N];
    bit            m_fresh  [N];   // channel restarts from zero on its next slot
    int            m_ch;
    bit            m_commit_armed, m_sync_armed;
    logic          m_pending;
    logic [CW-1:0] last_tuser;
    logic [OB-1:0] last_phase;
    int unsigned   edge_n = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Effect of the inputs currently driven at the coming clock edge.
    task automatic model_step();
        bit at_start;
        bit do_commit, do_sync;
        logic [PB-1:0] start_phase;
        exp_t e;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_phase[i] = '0; m_shadow[i] = '0; m_active[i] = '0; m_fresh[i] = 0;
            end
            m_ch = 0; m_commit_armed = 0; m_sync_armed = 0; m_pending = 1'b0;
            exp_q.delete();
            last_tuser = '0; last_phase = '0;
            return;
        end
        at_start  = tvalid_in && (m_ch == 0);
        do_commit = at_start && m_commit_armed;
        do_sync   = at_start && m_sync_armed;
        if (do_commit) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        if (do_sync)   for (int i = 0; i < N; i++) m_fresh[i] = 1;
        if (tvalid_in) begin
            start_phase = m_fresh[m_ch] ? '0 : m_phase[m_ch];
            m_fresh[m_ch] = 0;
            e.due   = edge_n + LAT;
            e.tuser = CW'(m_ch);
            e.phase = OB'(start_phase >> (PB - OB));
            exp_q.push_back(e);
            m_phase[m_ch] = start_phase + m_active[m_ch];
            m_ch = (m_ch + 1) % N;
        end
        if (do_commit)       m_commit_armed = 0;
        else if (fcw_commit) m_commit_armed = 1;
        if (do_sync)         m_sync_armed = 0;
        else if (phase_sync) m_sync_armed = 1;
        if (fcw_wr_en) m_shadow[fcw_wr_addr] = fcw_wr_data;
        m_pending = m_commit_armed | m_sync_armed;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic exp_v;
        exp_t e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        check_eq("tvalid_out", {31'd0, tvalid_out}, {31'd0, exp_v});
        if (exp_v) begin
            e = exp_q.pop_front();
            last_tuser = e.tuser;
            last_phase = e.phase;
        end
        check_eq("tuser_out", {29'd0, tuser_out}, {29'd0, last_tuser});
        check_eq("phase_out", {16'd0, phase_out}, {16'd0, last_phase});
        check_eq("update_pending", {31'd0, update_pending}, {31'd0, m_pending});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic rn, input logic v, input logic we,
                               input logic [CW-1:0] addr, input logic [PB-1:0] data,
                               input logic cm, input logic sy);
        resetn = rn; tvalid_in = v; fcw_wr_en = we; fcw_wr_addr = addr;
        fcw_wr_data = data; fcw_commit = cm; phase_sync = sy;
        model_step();
        edge_n++;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_valid(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 1, 0, '0, '0, 0, 0);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic write_fcw(input int ch, input logic [PB-1:0] w);
        drive_cycle(1, 0, 1, CW'(ch), w, 0, 0);
    endtask

    // Bounded: at most one round of valid slots.
    task automatic advance_to(input int target);
        for (int i = 0; i < N && m_ch != target; i++) run_valid(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_cycle(0, 1'($urandom_range(0, 1)), 0, '0, '0, 0, 0);
        run_idle(2);

        // ch0 steps by 1/16 turn per round; other channels stay at zero
        write_fcw(0, 32'h1000_0000);
        drive_cycle(1, 0, 0, '0, '0, 1, 0);
        run_valid(3 * N);

        // ch3 half-turn wrap, then a 5-cycle gap mid-round
        write_fcw(3, 32'h8000_0000);
        drive_cycle(1, 1, 0, '0, '0, 1, 0);
        run_valid(2 * N + 2);
        run_idle(5);
        run_valid(2 * N);

        // commit pulsed on ch5
        for (int i = 0; i < N; i++) write_fcw(i, $urandom());
        advance_to(5);
        drive_cycle(1, 1, 0, '0, '0, 1, 0);
        run_valid(12);

        // commit pulsed on a ch0 slot applies one round later
        for (int i = 0; i < N; i++) write_fcw(i, $urandom());
        advance_to(0);
        drive_cycle(1, 1, 0, '0, '0, 1, 0);
        run_valid(2 * N + 3);

        // phase sync mid-round after 10 rounds
        run_valid(10 * N);
        advance_to(3);
        drive_cycle(1, 1, 0, '0, '0, 0, 1);
        run_valid(3 * N);

        // commit and sync armed together
        write_fcw(6, $urandom());
        drive_cycle(1, 1, 0, '0, '0, 1, 1);
        drive_cycle(1, 1, 0, '0, '0, 1, 1);
        run_valid(2 * N);

        // shadow write to ch2 in the apply cycle stays in shadow
        write_fcw(2, 32'h0400_0000);
        drive_cycle(1, 0, 0, '0, '0, 1, 0);
        advance_to(N - 1);
        run_valid(1);
        drive_cycle(1, 1, 1, CW'(2), 32'h2000_0000, 0, 0);
        run_valid(2 * N);
        drive_cycle(1, 0, 0, '0, '0, 1, 0);
        run_valid(2 * N);

        // reset mid-round with tvalid_in high
        advance_to(4);
        drive_cycle(0, 1, 0, '0, '0, 0, 0);
        run_valid(N + 4);
        write_fcw(1, 32'h0100_0000);
        drive_cycle(1, 1, 0, '0, '0, 1, 0);
        run_valid(2 * N);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive_cycle(1'($urandom_range(0, 250) != 0),
                        1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 5) == 0),
                        CW'($urandom_range(0, N - 1)),
                        $urandom(),
                        1'($urandom_range(0, 25) == 0),
                        1'($urandom_range(0, 40) == 0));
        end

        run_idle(LAT + 3);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jb_dfe_nco_phase_acc.md
# jb_dfe_nco_phase_acc

Time-division-multiplexed NCO phase accumulator for the DFE mixer. It pairs with the data/NCO latency aligner. The input stream interleaves carrier/antenna channels (0:C0A0 … 3:C0A3, 4:C1A0 … 7:C1A3), and this block produces one mixer phase per valid sample, NCO_LATENCY cycles later. That output lands on the same cycle as the aligner's delayed data. Frequency words are host-written into shadow registers and applied atomically at a channel-0 boundary.

## Interface
- N_CHANNELS, 8: interleaved channels per TDM round (carriers × antennas); ≥2.
- PHASE_BW, 32: accumulator / frequency-control-word width.
- OUT_BW, 16: phase output width (MSBs of accumulator); OUT_BW ≤ PHASE_BW.
- NCO_LATENCY, 3: tvalid_in → tvalid_out latency in cycles; ≥1; must equal aligner's NCO_LATENCY.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- tvalid_in  in  1  one TDM sample slot this cycle.
- fcw_wr_en  in  1  write shadow FCW.
- fcw_wr_addr  in  CH_BW  shadow channel index; CH_BW = $clog2(N_CHANNELS); addresses ≥ N_CHANNELS ignored.
- fcw_wr_data  in  PHASE_BW  unsigned FCW (phase increment per round).
- fcw_commit  in  1  pulse: copy all shadow FCWs to active at next boundary.
- phase_sync  in  1  pulse: zero all channel phases at next boundary.
- tvalid_out  out  1  phase_out/tuser_out valid.
- tuser_out  out  CH_BW  channel index of phase_out.
- phase_out  out  OUT_BW  acc[PHASE_BW-1 -: OUT_BW], truncated.
- update_pending  out  1  commit or sync armed, not yet applied.

## Operation
- Channel counter ch: advances only on tvalid_in; 0→N_CHANNELS-1→0. Gaps in tvalid_in freeze all state.
- Per valid slot on channel ch: emit phase = acc[ch] (pre-update value); acc[ch] ← acc[ch] + fcw_active[ch] mod 2^PHASE_BW.
- Boundary = a tvalid_in cycle with ch==0.
- fcw_commit/phase_sync set sticky flags. Flags apply at the first boundary strictly after the pulse cycle; a boundary in the pulse cycle does not count.
- Commit apply: fcw_active ← fcw_shadow for all channels. The update for this slot uses the new word. A shadow write in the apply cycle is not included; it stays in shadow.
- Sync apply: a per-channel zero mask is set for all channels. Each channel's next slot in the round outputs 0, its acc ← fcw_active (new if commit applies in the same cycle), and its mask bit clears.
- Commit and sync may be armed together; both apply at the same boundary. Repeated pulses while armed are absorbed.
- update_pending = commit_flag | sync_flag; clears the cycle after apply.
- Reset (any time, including mid-round): acc, fcw_shadow, fcw_active, ch, flags, mask = 0. The pipeline is flushed. Outputs go to tvalid_out=0, tuser_out=0, phase_out=0, update_pending=0.

## Timing
- tvalid_in at cycle t → tvalid_out at t+NCO_LATENCY with that slot's tuser_out/phase_out.
- tvalid_out is 0 otherwise. Data outputs hold their last value when not valid.
- Accumulator read/update in one cycle, followed by NCO_LATENCY-1 register stages; all outputs registered.
- FCW write visible in shadow the next cycle. Throughput: one slot per cycle, no backpressure.

## Structure
- Package jb_dfe_nco_pkg: CH_BW helper, phase_t/fcw_t typedefs, channel-order constants shared with the aligner.
- Sub-module jb_dfe_nco_delay_line: parameterized valid+data register pipeline (depth, width, reset to 0). It carries {tuser, phase} for the NCO_LATENCY-1 trailing stages.

## Test plan
- Defaults, fcw ch0=0x1000_0000 committed, continuous tvalid_in → ch0 phase_out 0x0000, 0x1000, 0x2000… every 8 valids. Other channels output 0. tuser_out cycles 0..7.
- ch3 fcw=0x8000_0000 → ch3 outputs 0x0000, 0x8000, 0x0000 (wrap). A tvalid_in gap of 5 cycles shifts outputs by 5 with no phase change.
- fcw_commit pulsed while ch=5 → update_pending=1; new words apply at the next ch0 slot, and update_pending drops the cycle after. A commit pulse on a ch0 slot applies one round later.
- phase_sync mid-round after 10 rounds → channels 0..7 each output 0 in the next round, then advance by their FCW.
- Reset asserted mid-round with tvalid_in high → the next cycle has all outputs 0 and the pipeline flushed. After release, the first slot is tuser_out=0, phase 0, at latency 3.
- Shadow write to ch2 in the apply cycle → ch2 keeps its old FCW until the next commit.
